// File: rtl/poly_term_derivative.sv
// rtl/poly_term_derivative.sv - k-th order power-rule derivative of one polynomial term
//
// Takes (coef, e, k) and returns coef*e*(e-1)*...*(e-k+1) at exponent e-k.
// Each factor is applied by a shift-add multiplier, one multiplier bit per cycle,
// with saturation checked after every factor.
//
// Build option: SIGNED_COEF_EN makes in_coef/out_coef two's complement
// (magnitude multiplied, sign reapplied, saturation to the signed range).
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  input term handshake
//   in_coef, in_exp,   term coefficient, exponent e, derivative order k
//   in_order
//   out_valid/out_ready result handshake
//   out_coef, out_exp  derivative coefficient and exponent
//   out_zero, out_ovf  coefficient is zero / coefficient saturated
//   busy               engine not idle
module poly_term_derivative #(
   parameter int COEF_W = 8,
   parameter int EXP_W  = 4,
   parameter int OUT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [COEF_W-1:0] in_coef,
   input  logic [EXP_W-1:0]  in_exp,
   input  logic [EXP_W-1:0]  in_order,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_coef,
   output logic [EXP_W-1:0]  out_exp,
   output logic              out_zero,
   output logic              out_ovf,
   output logic              busy
);

   localparam int ACC_W = OUT_W + EXP_W;
   localparam int BC_W  = (EXP_W > 1) ? $clog2(EXP_W) : 1;
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(EXP_W - 1);

   typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;
   state_t state, state_nx;

   logic [ACC_W-1:0] acc;      // running coefficient magnitude (multiplicand)
   logic [ACC_W-1:0] prod;     // partial product of the factor in progress
   logic [EXP_W-1:0] f;        // current factor (multiplier)
   logic [EXP_W-1:0] cnt;      // factors remaining
   logic [BC_W-1:0]  bcnt;     // multiplier bit being processed
   logic             sign_q;
   logic             ovf;

   logic             accept;
   logic             coef_neg;
   logic [ACC_W-1:0] in_mag;
   logic [ACC_W-1:0] lim;
   logic [ACC_W-1:0] prod_nx;
   logic [ACC_W-1:0] fac_val;
   logic             fac_ovf;

`ifdef SIGNED_COEF_EN
   localparam logic [ACC_W-1:0] LIM_P = ACC_W'({(OUT_W-1){1'b1}});
   localparam logic [ACC_W-1:0] LIM_N = LIM_P + ACC_W'(1);
   logic [COEF_W:0] coef_mag;
   always_comb begin
      coef_neg = in_coef[COEF_W-1];
      // One extra bit so the most negative input keeps its magnitude.
      coef_mag = coef_neg ? ({1'b0, ~in_coef} + 1'b1) : {1'b0, in_coef};
      in_mag   = ACC_W'(coef_mag);
      lim      = sign_q ? LIM_N : LIM_P;
   end
`else
   always_comb begin
      coef_neg = 1'b0;
      in_mag   = ACC_W'(in_coef);
      lim      = ACC_W'({OUT_W{1'b1}});
   end
`endif

   // Magnitude never exceeds the saturation limit, so the low OUT_W bits hold it exactly.
   function automatic logic [OUT_W-1:0] to_out(input logic [ACC_W-1:0] mag, input logic neg);
      to_out = neg ? (~mag[OUT_W-1:0] + 1'b1) : mag[OUT_W-1:0];
   endfunction

   always_comb begin
      prod_nx = prod + (f[bcnt] ? (acc << bcnt) : '0);
      // Factors are all >= 1, so once saturated the product stays above the limit.
      fac_ovf = (prod_nx > lim);
      fac_val = fac_ovf ? lim : prod_nx;
   end

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy     = 1'b0;
            in_ready = !rst;
            if (in_valid && !rst) begin
               if (in_order == '0 || in_order > in_exp) state_nx = OUT;
               else                                     state_nx = MUL;
            end
         end
         MUL: begin
            if (bcnt == BC_LAST && cnt == EXP_W'(1)) state_nx = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         prod     <= '0;
         f        <= '0;
         cnt      <= '0;
         bcnt     <= '0;
         sign_q   <= 1'b0;
         ovf      <= 1'b0;
         out_coef <= '0;
         out_exp  <= '0;
         out_zero <= 1'b0;
         out_ovf  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  acc     <= in_mag;
                  prod    <= '0;
                  f       <= in_exp;
                  cnt     <= in_order;
                  bcnt    <= '0;
                  sign_q  <= coef_neg;
                  ovf     <= 1'b0;
                  out_exp <= (in_order > in_exp) ? '0 : (in_exp - in_order);
                  if (in_order == '0) begin
                     out_coef <= to_out(in_mag, coef_neg);
                     out_zero <= (in_mag == '0);
                     out_ovf  <= 1'b0;
                  end else if (in_order > in_exp) begin
                     out_coef <= '0;
                     out_zero <= 1'b1;
                     out_ovf  <= 1'b0;
                  end
               end
            end
            MUL: begin
               if (bcnt == BC_LAST) begin
                  acc  <= fac_val;
                  prod <= '0;
                  bcnt <= '0;
                  f    <= f - 1'b1;
                  cnt  <= cnt - 1'b1;
                  ovf  <= ovf | fac_ovf;
                  if (cnt == EXP_W'(1)) begin
                     out_coef <= to_out(fac_val, sign_q);
                     out_zero <= (fac_val == '0);
                     out_ovf  <= ovf | fac_ovf;
                  end
               end else begin
                  prod <= prod_nx;
                  bcnt <= bcnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/poly_term_derivative.md
# poly_term_derivative

Sequential power-rule engine for the calculator datapath. It accepts one polynomial term (coefficient, exponent) plus a derivative order k over a valid/ready handshake. It returns the k-th derivative term: coef·e·(e−1)·…·(e−k+1) at exponent e−k. It generalises the single-order combinational derivative unit with parametrised widths, arbitrary order, overflow saturation and flow control, and sits between the term parser and the result formatter.

## Interface
- COEF_W, 8: input coefficient width.
- EXP_W, 4: exponent and order width; also the cycles per multiply factor.
- OUT_W, 16: output coefficient width. Must be ≥ COEF_W.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input term valid.
- in_ready  out  1  engine can accept a term.
- in_coef  in  COEF_W  term coefficient.
- in_exp  in  EXP_W  term exponent e.
- in_order  in  EXP_W  derivative order k.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_coef  out  OUT_W  derivative coefficient.
- out_exp  out  EXP_W  derivative exponent.
- out_zero  out  1  result coefficient is zero.
- out_ovf  out  1  coefficient saturated.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, MUL, OUT.
- IDLE: in_ready=1. On in_valid&&in_ready, latch coef, e and k. Also set acc=coef, f=e, cnt=k, and clear ovf.
  - If k==0: result = coef zero-extended, exp=e. Go to OUT.
  - If k>e: result coef=0, exp=0. Go to OUT.
  - Otherwise go to MUL.
- MUL: computes acc ← acc·f using a shift-add multiplier over an internal OUT_W+EXP_W accumulator, one multiplier bit per cycle, LSB first, EXP_W cycles per factor.
  - After each factor: if any bit above OUT_W−1 is set, set ovf and clamp acc to 2^OUT_W−1.
  - Then f←f−1 and cnt←cnt−1. When cnt reaches 0, go to OUT.
  - Once ovf is set, the final coefficient is the saturated value.
- OUT: out_valid=1 and outputs hold stable. out_exp=e−k, out_zero=(out_coef==0), out_ovf=ovf. On out_ready, go to IDLE.
- in_ready is 0 in MUL and OUT. There is one term in flight; no input is accepted in the same cycle as an output handshake.
- All factors are ≥1 when k≤e, so a zero result arises only from coef==0 or the k>e case.

## Timing
- Reset values: in_ready=0 while rst is high, then 1 in the first cycle after rst deasserts. out_valid, out_coef, out_exp, out_zero, out_ovf and busy are 0.
- rst mid-MUL or mid-OUT aborts the term; no output is produced for it.
- Latency, measured from the input handshake at cycle t:
  - out_valid rises at t+1 for k==0 or k>e.
  - out_valid rises at t+1+k·EXP_W otherwise.
- Output handshake at cycle u: out_valid=0 and in_ready=1 at u+1.
- Under backpressure, outputs are frozen until out_ready.
- out_* are registered; none is combinational from inputs.

## Configuration
- SIGNED_COEF_EN defined:
  - in_coef and out_coef are two's complement.
  - Magnitude is multiplied and the sign reapplied.
  - On overflow, saturate to +(2^(OUT_W−1)−1) or −2^(OUT_W−1) according to the sign.
  - in_coef is sign-extended for k==0.
- SIGNED_COEF_EN undefined: coefficients are unsigned, zero-extended, and saturate to 2^OUT_W−1.

## Test plan
- Defaults, coef=3, e=2, k=1 → out_coef=6, out_exp=1, out_zero=0, out_ovf=0; out_valid 5 cycles after accept.
- coef=0, e=2, k=1 → out_coef=0, out_exp=1, out_zero=1. Then coef=3, e=0, k=1 → out_coef=0, out_exp=0, out_zero=1, out_valid 1 cycle after accept.
- coef=15, e=15, k=1 → 225 at exp 14. Then coef=5, e=4, k=0 → 5 at exp 4 after 1 cycle.
- coef=255, e=15, k=3 → 255·15·14·13=696150 exceeds 2^16 → out_coef=65535, out_ovf=1, out_exp=12, latency 13 cycles.
- Backpressure: hold out_ready=0 for 5 cycles with a result pending → out_* stable, in_ready=0, extra in_valid is ignored. Release → single handshake, in_ready=1 the next cycle.
- Assert rst for 1 cycle mid-MUL → out_valid never rises for that term. in_ready=1 the cycle after rst falls. The next term (coef=2, e=3, k=2 → 12 at exp 1) is correct.
